// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame constants and the baud divider helper.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Sysclk cycles per oversample tick, rounded down.
    function automatic int unsigned uart_calc_div(input int unsigned clk_freq,
                                                  input int unsigned baud,
                                                  input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1, pulses tick_o on the last count.
// A synchronous clear restarts the phase so a receiver can align ticks to a start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises rxd, oversamples 8N1 frames and hands bytes over valid/ack.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop, with an rx_parity_err pulse.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ack,
    output logic                      rx_overrun,
    output logic                      rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      rx_parity_err
`endif
);

    localparam int unsigned DIV = uart_calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BIW = $clog2(UART_DATA_BITS);
    localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] FULL_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BIW-1:0] LAST_BIT  = BIW'(UART_DATA_BITS - 1);

    logic rxd_meta_q;
    logic rxd_s_q;
    logic rxd_d_q;
    logic start_edge;
    logic tick;
    logic tick_clear;

    rx_state_e state_q, state_d;
    logic [SCW-1:0]            sample_cnt_q, sample_cnt_d;
    logic [BIW-1:0]            bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      stop_sample;
    logic                      parity_ok;
    logic                      deliver;
    logic                      frame_err_ev;

    logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      rx_overrun_q, rx_overrun_d;
    logic                      frame_err_q;

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
    logic parity_err_ev;
    logic parity_err_q;
`endif

    // Synchroniser and edge history all idle high so reset never fakes a start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxd_meta_q <= UART_IDLE_LEVEL;
            rxd_s_q    <= UART_IDLE_LEVEL;
            rxd_d_q    <= UART_IDLE_LEVEL;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_d_q    <= rxd_s_q;
        end
    end

    assign start_edge = rxd_d_q & ~rxd_s_q;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk_i  (sysclk),
        .reset_i(reset),
        .clear_i(tick_clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        tick_clear   = 1'b0;
        stop_sample  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    tick_clear   = 1'b1;
                    sample_cnt_d = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt_q == HALF_LAST) begin
                        sample_cnt_d = '0;
                        bit_idx_d    = '0;
                        state_d      = rxd_s_q ? IDLE : DATA;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d       = '0;
                        shift_d[bit_idx_q] = rxd_s_q;
                        bit_idx_d          = bit_idx_q + BIW'(1);
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d = '0;
                        parity_bit_d = rxd_s_q;
                        state_d      = STOP;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d = '0;
                        stop_sample  = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign parity_ok     = ~(^{shift_q, parity_bit_q});
    assign parity_err_ev = stop_sample & rxd_s_q & ~parity_ok;
`else
    assign parity_ok     = 1'b1;
`endif
    assign frame_err_ev = stop_sample & ~rxd_s_q;
    assign deliver      = stop_sample & rxd_s_q & parity_ok;

    // A delivery racing an ack replaces the byte; without an ack the new byte is dropped.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (deliver) begin
            if (rx_valid_q && !rx_ack) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_ev;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_ev;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at DIV=10 (160 sysclk cycles per bit).
// Honours UART_RX_PARITY_EN: frames gain an even-parity bit and a wrong-parity case is added.
module tb_uart_rx_frontend;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD       = 10_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int BIT_CYCLES = 160;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS        = 10 + PAR_BITS;
    localparam int FRAME_CYCLES = NBITS * BIT_CYCLES;
    // Stop sample lands 8 + 16*(9+parity) ticks of 10 cycles after the start edge is
    // acted on, which is 3 cycles after rxd falls (two synchroniser flops plus the edge check).
    localparam int STOP_TICKS = 8 + 16 * (9 + PAR_BITS);
    localparam int VALID_LAT  = 3 + 10 * STOP_TICKS;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int firstValid;
    int frameErrCycles;
    int parityErrCycles;
    int badCycles;

    uart_rx_frontend #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic pulseAck();
        rx_ack = 1'b1;
        waitCycles(1);
        rx_ack = 1'b0;
    endtask

    // Drives one frame starting just after a clock edge; c counts cycles from the rxd fall.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityFlip,
                                 input int ackAt, input int resetAt,
                                 output int firstRise, output int ferr, output int perr);
        int   slot;
        logic prevValid;
        logic [7:0] d;
        d = data;
        firstRise = -1;
        ferr = 0;
        perr = 0;
        prevValid = rx_valid;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            if (resetAt >= 0 && c == resetAt + 1) begin
                checkOutput("resetData", 32'(rx_data), 32'h0);
                checkOutput("resetValid", 32'(rx_valid), 32'h0);
                checkOutput("resetOverrun", 32'(rx_overrun), 32'h0);
                checkOutput("resetFrameErr", 32'(rx_frame_err), 32'h0);
            end
            slot = c / BIT_CYCLES;
            if (slot == 0) rxd = 1'b0;
            else if (slot <= 8) rxd = d[3'(slot - 1)];
            else if (slot == 9 && PAR_BITS == 1) rxd = (^d) ^ parityFlip;
            else rxd = stopBit;
            rx_ack = (c == ackAt);
            reset  = (c == resetAt);
            @(posedge sysclk);
            #1;
            if (rx_valid && !prevValid && firstRise < 0) firstRise = c + 1;
            prevValid = rx_valid;
            if (rx_frame_err) ferr++;
`ifdef UART_RX_PARITY_EN
            if (rx_parity_err) perr++;
`endif
        end
        rx_ack = 1'b0;
        reset  = 1'b0;
        rxd    = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        waitCycles(3);
        reset = 1'b0;
        checkOutput("rstData", 32'(rx_data), 32'h0);
        checkOutput("rstValid", 32'(rx_valid), 32'h0);
        checkOutput("rstOverrun", 32'(rx_overrun), 32'h0);
        checkOutput("rstFrameErr", 32'(rx_frame_err), 32'h0);
        waitCycles(20);

        applyStimulus(8'hA5, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("a5Latency", 32'(firstValid), 32'(VALID_LAT));
        checkOutput("a5Data", 32'(rx_data), 32'hA5);
        checkOutput("a5FrameErr", 32'(frameErrCycles), 32'h0);
        pulseAck();
        checkOutput("a5AckValid", 32'(rx_valid), 32'h0);
        checkOutput("a5AckHold", 32'(rx_data), 32'hA5);
        waitCycles(20);

        // Short low pulse: START sees a high line at its midpoint and gives up.
        badCycles = 0;
        rxd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            waitCycles(1);
            if (rx_valid || rx_frame_err) badCycles++;
        end
        rxd = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            waitCycles(1);
            if (rx_valid || rx_frame_err) badCycles++;
        end
        checkOutput("glitchQuiet", 32'(badCycles), 32'h0);

        applyStimulus(8'h3C, 1'b0, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("ferrPulse", 32'(frameErrCycles), 32'h1);
        checkOutput("ferrNoValid", 32'(rx_valid), 32'h0);
        waitCycles(20);
        applyStimulus(8'h11, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("after11Data", 32'(rx_data), 32'h11);
        checkOutput("after11Valid", 32'(rx_valid), 32'h1);
        pulseAck();
        waitCycles(20);

        applyStimulus(8'h12, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        waitCycles(20);
        applyStimulus(8'h34, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("ovrData", 32'(rx_data), 32'h12);
        checkOutput("ovrValid", 32'(rx_valid), 32'h1);
        checkOutput("ovrFlag", 32'(rx_overrun), 32'h1);
        pulseAck();
        checkOutput("ovrAckFlag", 32'(rx_overrun), 32'h0);
        checkOutput("ovrAckValid", 32'(rx_valid), 32'h0);
        waitCycles(20);

        applyStimulus(8'h12, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        waitCycles(20);
        applyStimulus(8'h56, 1'b1, 1'b0, VALID_LAT - 1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("raceData", 32'(rx_data), 32'h56);
        checkOutput("raceValid", 32'(rx_valid), 32'h1);
        checkOutput("raceOverrun", 32'(rx_overrun), 32'h0);
        waitCycles(20);

        // Reset lands in the middle of data bit 4 (slot 5) with the 0x56 byte still pending.
        applyStimulus(8'hFF, 1'b1, 1'b0, -1, 5 * BIT_CYCLES + 80, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("ffDropped", 32'(rx_valid), 32'h0);
        waitCycles(20);
        applyStimulus(8'h81, 1'b1, 1'b0, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("x81Data", 32'(rx_data), 32'h81);
        checkOutput("x81Latency", 32'(firstValid), 32'(VALID_LAT));
        checkOutput("x81FrameErr", 32'(frameErrCycles), 32'h0);
        pulseAck();
        waitCycles(20);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h81, 1'b1, 1'b1, -1, -1, firstValid, frameErrCycles, parityErrCycles);
        checkOutput("parErrPulse", 32'(parityErrCycles), 32'h1);
        checkOutput("parNoValid", 32'(rx_valid), 32'h0);
        checkOutput("parNoFrameErr", 32'(frameErrCycles), 32'h0);
        waitCycles(20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
